// File: rtl/fpu_op_dispatcher.sv
// ============================================================================
// fpu_op_dispatcher
// ----------------------------------------------------------------------------
// Issue/collect stage for the single-precision FPU. One operation request
// (operands A, B and an opcode) is accepted over a valid/ready handshake and
// registered. The registered operands and opcode drive the per-unit demux
// inputs, and a one-cycle start strobe kicks the arithmetic units. The
// dispatcher then waits for the selected unit's done flag, captures that
// unit's result and presents it on a valid/ready response port. Only one
// operation is ever in flight.
//
// Optional feature macro: FPU_DISPATCH_TIMEOUT_EN
//    When defined, a watchdog counter runs while waiting for the selected
//    unit. If the unit has not finished after TIMEOUT_CYCLES wait cycles,
//    a quiet-NaN response is produced with rsp_timeout set. When undefined,
//    the dispatcher waits forever and rsp_timeout is tied low.
//
// Parameters:
//    DATA_WIDTH      operand/result width (IEEE-754 single = 32)
//    OP_WIDTH        opcode width; 0 add, 1 sub, 2 mul, 3 div
//    TIMEOUT_CYCLES  watchdog limit in wait cycles (timeout build only)
//
// Ports:
//    clk, rst                  clock, asynchronous active-high reset
//    req_valid/req_ready       request handshake
//    req_a, req_b, req_opcode  request operands and operation select
//    unit_a, unit_b            registered operands to the unit demux
//    unit_opcode               registered opcode to the demux select
//    unit_start                one-cycle start strobe to the units
//    unit_done[3:0]            per-unit done (add, sub, mul, div)
//    res_add/sub/mul/div       unit results, valid while matching done is high
//    rsp_valid/rsp_ready       response handshake
//    rsp_result, rsp_opcode    captured result and its opcode
//    rsp_timeout               response was produced by the watchdog
//    busy                      high whenever the dispatcher is not idle
// ============================================================================

module fpu_op_dispatcher #(
   parameter int DATA_WIDTH     = 32,
   parameter int OP_WIDTH       = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [DATA_WIDTH-1:0] req_a,
   input  logic [DATA_WIDTH-1:0] req_b,
   input  logic [OP_WIDTH-1:0]   req_opcode,

   output logic [DATA_WIDTH-1:0] unit_a,
   output logic [DATA_WIDTH-1:0] unit_b,
   output logic [OP_WIDTH-1:0]   unit_opcode,
   output logic                  unit_start,
   input  logic [3:0]            unit_done,
   input  logic [DATA_WIDTH-1:0] res_add,
   input  logic [DATA_WIDTH-1:0] res_sub,
   input  logic [DATA_WIDTH-1:0] res_mul,
   input  logic [DATA_WIDTH-1:0] res_div,

   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_result,
   output logic [OP_WIDTH-1:0]   rsp_opcode,
   output logic                  rsp_timeout,
   output logic                  busy
);

   // Opcode encodings, also used as the index into unit_done.
   localparam logic [OP_WIDTH-1:0] OpAdd = OP_WIDTH'(0);
   localparam logic [OP_WIDTH-1:0] OpSub = OP_WIDTH'(1);
   localparam logic [OP_WIDTH-1:0] OpMul = OP_WIDTH'(2);
   localparam logic [OP_WIDTH-1:0] OpDiv = OP_WIDTH'(3);

   // Result reported when the watchdog fires: IEEE-754 single quiet NaN.
   localparam logic [DATA_WIDTH-1:0] QuietNan = DATA_WIDTH'(32'h7FC0_0000);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StResp  = 2'd3
   } state_e;

   state_e                state_q;
   state_e                state_d;

   logic [DATA_WIDTH-1:0] unitA_q;
   logic [DATA_WIDTH-1:0] unitB_q;
   logic [OP_WIDTH-1:0]   unitOpcode_q;
   logic [DATA_WIDTH-1:0] rspResult_q;
   logic [OP_WIDTH-1:0]   rspOpcode_q;

   logic                  accept;
   logic                  selDone;
   logic                  timeoutHit;
   logic [DATA_WIDTH-1:0] selResult;

   // A request is taken only in IDLE. The state is frozen in IDLE while rst
   // is asserted, so no extra reset qualification is needed here.
   assign accept = (state_q == StIdle) && req_valid;

   // Only the done bit of the unit we actually started matters; the other
   // units may be finishing stale work and their flags are ignored.
   assign selDone = unit_done[unitOpcode_q];

   // Result mux steered by the registered opcode, so the capture always
   // comes from the unit that was started.
   always_comb begin
      selResult = '0;
      case (unitOpcode_q)
         OpAdd:   selResult = res_add;
         OpSub:   selResult = res_sub;
         OpMul:   selResult = res_mul;
         OpDiv:   selResult = res_div;
         default: selResult = '0;
      endcase
   end

`ifdef FPU_DISPATCH_TIMEOUT_EN
   localparam int CountWidth = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CountWidth-1:0] CountLast = CountWidth'(TIMEOUT_CYCLES - 1);

   logic [CountWidth-1:0] waitCount_q;
   logic                  rspTimeout_q;

   // Watchdog counter: cleared while issuing (so it is zero on entry to
   // WAIT) and advanced once per WAIT cycle. It holds the number of WAIT
   // cycles already completed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         waitCount_q <= '0;
      end else if (state_q == StIssue) begin
         waitCount_q <= '0;
      end else if (state_q == StWait) begin
         waitCount_q <= waitCount_q + 1'b1;
      end
   end

   // The counter reaches TIMEOUT_CYCLES at the end of this WAIT cycle, so
   // the watchdog fires after exactly TIMEOUT_CYCLES WAIT cycles.
   assign timeoutHit = (state_q == StWait) && (waitCount_q == CountLast);

   // Timeout flag travels with the response. A real done in the same cycle
   // as the watchdog takes priority and leaves the flag clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rspTimeout_q <= 1'b0;
      end else if (state_q == StWait) begin
         if (selDone) begin
            rspTimeout_q <= 1'b0;
         end else if (timeoutHit) begin
            rspTimeout_q <= 1'b1;
         end
      end
   end

   assign rsp_timeout = rspTimeout_q;
`else
   // Without the watchdog WAIT lasts until the selected unit finishes.
   assign timeoutHit  = 1'b0;
   assign rsp_timeout = 1'b0;

   logic unusedTimeoutCfg;
   assign unusedTimeoutCfg = ^TIMEOUT_CYCLES;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. ISSUE is always a single cycle because the units
   // never report done in the same cycle they are started. RESP only
   // returns to IDLE, so a new request cannot be taken in the cycle the
   // response is consumed.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StIssue;
            end
         end
         StIssue: begin
            state_d = StWait;
         end
         StWait: begin
            if (selDone || timeoutHit) begin
               state_d = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Output decode. req_ready is additionally masked by rst so that it
   // reads low for the whole reset and rises in the first IDLE cycle after
   // release.
   always_comb begin
      req_ready  = (state_q == StIdle) && !rst;
      unit_start = (state_q == StIssue);
      rsp_valid  = (state_q == StResp);
      busy       = (state_q != StIdle);
   end

   // Datapath registers. Operands and opcode are loaded on accept and then
   // held (also across the return to IDLE) until the next accept. The
   // response fields are loaded only on the WAIT exit and are therefore
   // stable for as long as RESP is back-pressured.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         unitA_q      <= '0;
         unitB_q      <= '0;
         unitOpcode_q <= '0;
         rspResult_q  <= '0;
         rspOpcode_q  <= '0;
      end else begin
         if (accept) begin
            unitA_q      <= req_a;
            unitB_q      <= req_b;
            unitOpcode_q <= req_opcode;
         end
         if (state_q == StWait) begin
            if (selDone) begin
               rspResult_q <= selResult;
               rspOpcode_q <= unitOpcode_q;
            end else if (timeoutHit) begin
               rspResult_q <= QuietNan;
               rspOpcode_q <= unitOpcode_q;
            end
         end
      end
   end

   assign unit_a      = unitA_q;
   assign unit_b      = unitB_q;
   assign unit_opcode = unitOpcode_q;
   assign rsp_result  = rspResult_q;
   assign rsp_opcode  = rspOpcode_q;

endmodule

// File: tb/tb_fpu_op_dispatcher.sv
// ============================================================================
// tb_fpu_op_dispatcher
// ----------------------------------------------------------------------------
// Self-checking bench for fpu_op_dispatcher. All stimulus is driven and all
// outputs are observed on the falling clock edge. The expected behaviour is
// derived from the dispatcher's contract: the response carries the result of
// the unit named by the opcode, rsp_valid appears 2+L cycles after the accept
// edge when the unit finishes L cycles after start, and a watchdog response
// (timeout build only) is a quiet NaN after TIMEOUT_CYCLES wait cycles.
// ============================================================================

module tb_fpu_op_dispatcher;

   localparam int TB_TIMEOUT = 8;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic [1:0]  req_opcode = '0;
   logic [31:0] unit_a;
   logic [31:0] unit_b;
   logic [1:0]  unit_opcode;
   logic        unit_start;
   logic [3:0]  unit_done = '0;
   logic [31:0] res_add;
   logic [31:0] res_sub;
   logic [31:0] res_mul;
   logic [31:0] res_div;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_result;
   logic [1:0]  rsp_opcode;
   logic        rsp_timeout;
   logic        busy;

   // Behavioural unit model: one result register per unit, indexed by opcode.
   logic [31:0] resModel [4];

   int passCount  = 0;
   int checkCount = 0;

   assign res_add = resModel[0];
   assign res_sub = resModel[1];
   assign res_mul = resModel[2];
   assign res_div = resModel[3];

   always #5 clk = ~clk;

   fpu_op_dispatcher #(
      .DATA_WIDTH     (32),
      .OP_WIDTH       (2),
      .TIMEOUT_CYCLES (TB_TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_opcode  (req_opcode),
      .unit_a      (unit_a),
      .unit_b      (unit_b),
      .unit_opcode (unit_opcode),
      .unit_start  (unit_start),
      .unit_done   (unit_done),
      .res_add     (res_add),
      .res_sub     (res_sub),
      .res_mul     (res_mul),
      .res_div     (res_div),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .rsp_opcode  (rsp_opcode),
      .rsp_timeout (rsp_timeout),
      .busy        (busy)
   );

   // Presents one request for a single rising edge. Called on a falling edge
   // while the dispatcher is idle; returns on the falling edge of the cycle
   // after the accept edge (the ISSUE cycle).
   task automatic issueRequest(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      req_valid  = 1'b1;
      req_opcode = op;
      req_a      = a;
      req_b      = b;
      @(negedge clk);
      req_valid  = 1'b0;
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      req_valid = 1'b1;
      req_a     = $urandom;
      req_b     = $urandom;
      unit_done = 4'hF;
      repeat (3) @(negedge clk);
      checkCount++;
      if ({req_ready, unit_start, rsp_valid, busy, rsp_timeout} !== 5'b0)
         $display("[TB] FAIL reset_ctrl: got %b, expected 00000", {req_ready, unit_start, rsp_valid, busy, rsp_timeout});
      else passCount++;
      checkCount++;
      if ({unit_a, unit_b, unit_opcode} !== 66'b0)
         $display("[TB] FAIL reset_unit_regs: got a=%h b=%h op=%b, expected all zero", unit_a, unit_b, unit_opcode);
      else passCount++;
      checkCount++;
      if ({rsp_result, rsp_opcode} !== 34'b0)
         $display("[TB] FAIL reset_rsp_regs: got result=%h op=%b, expected all zero", rsp_result, rsp_opcode);
      else passCount++;
      req_valid = 1'b0;
      unit_done = 4'h0;
      rst       = 1'b0;
      #1;
      checkCount++;
      if ({req_ready, busy} !== 2'b10)
         $display("[TB] FAIL reset_release: got ready/busy=%b, expected 10", {req_ready, busy});
      else passCount++;
   endtask

   task automatic test_add_basic;
      @(negedge clk);
      rsp_ready = 1'b1;
      unit_done = 4'h0;
      issueRequest(2'b00, 32'h3F80_0000, 32'h4000_0000);
      checkCount++;
      if ({unit_start, unit_opcode, unit_a, unit_b} !== {1'b1, 2'b00, 32'h3F80_0000, 32'h4000_0000})
         $display("[TB] FAIL add_issue: got start=%b op=%b a=%h b=%h, expected 1 00 3f800000 40000000",
                  unit_start, unit_opcode, unit_a, unit_b);
      else passCount++;
      @(negedge clk);
      checkCount++;
      if ({unit_start, rsp_valid, busy} !== 3'b001)
         $display("[TB] FAIL add_wait: got start/valid/busy=%b, expected 001", {unit_start, rsp_valid, busy});
      else passCount++;
      unit_done   = 4'b0001;
      resModel[0] = 32'h4040_0000;
      @(negedge clk);
      unit_done = 4'h0;
      checkCount++;
      if (rsp_valid !== 1'b1)
         $display("[TB] FAIL add_latency: got rsp_valid=%b three cycles after accept, expected 1", rsp_valid);
      else passCount++;
      checkCount++;
      if ({rsp_opcode, rsp_timeout, rsp_result} !== {2'b00, 1'b0, 32'h4040_0000})
         $display("[TB] FAIL add_response: got op=%b to=%b result=%h, expected 00 0 40400000",
                  rsp_opcode, rsp_timeout, rsp_result);
      else passCount++;
      @(negedge clk);
      checkCount++;
      if ({rsp_valid, busy, req_ready} !== 3'b001)
         $display("[TB] FAIL add_return: got valid/busy/ready=%b, expected 001", {rsp_valid, busy, req_ready});
      else passCount++;
      checkCount++;
      if (unit_a !== 32'h3F80_0000)
         $display("[TB] FAIL add_operand_hold: got unit_a=%h, expected 3f800000", unit_a);
      else passCount++;
   endtask

   task automatic test_div_noise;
      logic earlyValid;
      earlyValid = 1'b0;
      @(negedge clk);
      resModel[3] = 32'h1234_5678;
      issueRequest(2'b11, $urandom, $urandom);
      @(negedge clk);
      unit_done   = 4'b0001;
      resModel[0] = 32'hDEAD_BEEF;
      @(negedge clk);
      unit_done = 4'h0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid) earlyValid = 1'b1;
         @(negedge clk);
      end
      if (rsp_valid) earlyValid = 1'b1;
      unit_done   = 4'b1000;
      resModel[3] = 32'h3F00_0000;
      @(negedge clk);
      unit_done = 4'h0;
      checkCount++;
      if ({earlyValid, rsp_valid} !== 2'b01)
         $display("[TB] FAIL div_valid: got early/valid=%b, expected 01", {earlyValid, rsp_valid});
      else passCount++;
      checkCount++;
      if ({rsp_opcode, rsp_result, rsp_timeout} !== {2'b11, 32'h3F00_0000, 1'b0})
         $display("[TB] FAIL div_response: got op=%b result=%h to=%b, expected 11 3f000000 0",
                  rsp_opcode, rsp_result, rsp_timeout);
      else passCount++;
      @(negedge clk);
      checkCount++;
      if (rsp_valid !== 1'b0)
         $display("[TB] FAIL div_handshake: got rsp_valid=%b after accept, expected 0", rsp_valid);
      else passCount++;
   endtask

   task automatic test_backpressure;
      logic [31:0] a;
      logic [31:0] r;
      a = $urandom;
      r = $urandom;
      @(negedge clk);
      issueRequest(2'b10, a, $urandom);
      @(negedge clk);
      unit_done   = 4'b0100;
      resModel[2] = r;
      rsp_ready   = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         checkCount++;
         if ({rsp_valid, req_ready, rsp_opcode, rsp_result, rsp_timeout} !== {1'b1, 1'b0, 2'b10, r, 1'b0})
            $display("[TB] FAIL bp_hold_%0d: got valid=%b ready=%b op=%b result=%h to=%b, expected 1 0 10 %h 0",
                     i, rsp_valid, req_ready, rsp_opcode, rsp_result, rsp_timeout, r);
         else passCount++;
         unit_done   = 4'($urandom);
         resModel[2] = $urandom;
         if (i == 4) begin
            req_valid = 1'b1;
            req_a     = ~a;
         end
         if (i == 5) req_valid = 1'b0;
         @(negedge clk);
      end
      unit_done = 4'h0;
      rsp_ready = 1'b1;
      @(negedge clk);
      checkCount++;
      if ({rsp_valid, busy, unit_start} !== 3'b000)
         $display("[TB] FAIL bp_release: got valid/busy/start=%b, expected 000", {rsp_valid, busy, unit_start});
      else passCount++;
      checkCount++;
      if (unit_a !== a)
         $display("[TB] FAIL bp_no_accept: got unit_a=%h, expected %h", unit_a, a);
      else passCount++;
   endtask

   task automatic test_reset_in_wait;
      logic lateActivity;
      lateActivity = 1'b0;
      @(negedge clk);
      issueRequest(2'($urandom_range(0, 3)), $urandom | 32'h1, $urandom | 32'h1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkCount++;
      if ({req_ready, unit_start, rsp_valid, busy, rsp_timeout} !== 5'b0)
         $display("[TB] FAIL rst_wait_ctrl: got %b, expected 00000", {req_ready, unit_start, rsp_valid, busy, rsp_timeout});
      else passCount++;
      checkCount++;
      if ({unit_a, unit_b, unit_opcode, rsp_result, rsp_opcode} !== 100'b0)
         $display("[TB] FAIL rst_wait_data: got a=%h b=%h op=%b result=%h rop=%b, expected all zero",
                  unit_a, unit_b, unit_opcode, rsp_result, rsp_opcode);
      else passCount++;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkCount++;
      if (req_ready !== 1'b1)
         $display("[TB] FAIL rst_wait_ready: got req_ready=%b after release, expected 1", req_ready);
      else passCount++;
      @(negedge clk);
      unit_done = 4'hF;
      for (int i = 0; i < 4; i++) resModel[i] = $urandom;
      @(negedge clk);
      unit_done = 4'h0;
      for (int i = 0; i < 5; i++) begin
         if (rsp_valid || busy) lateActivity = 1'b1;
         @(negedge clk);
      end
      checkCount++;
      if (lateActivity !== 1'b0)
         $display("[TB] FAIL rst_wait_no_rsp: got activity=%b after late done, expected 0", lateActivity);
      else passCount++;
   endtask

   task automatic test_timeout;
`ifdef FPU_DISPATCH_TIMEOUT_EN
      int          steps;
      logic [31:0] r;
      steps = 0;
      r     = $urandom;
      @(negedge clk);
      issueRequest(2'b10, $urandom, $urandom);
      unit_done = 4'b1011;
      while (!rsp_valid && steps < 100) begin
         @(negedge clk);
         steps++;
      end
      unit_done = 4'h0;
      checkCount++;
      if (steps !== TB_TIMEOUT + 1)
         $display("[TB] FAIL timeout_latency: got rsp_valid %0d cycles after issue, expected %0d", steps, TB_TIMEOUT + 1);
      else passCount++;
      checkCount++;
      if ({rsp_result, rsp_timeout, rsp_opcode} !== {QNAN, 1'b1, 2'b10})
         $display("[TB] FAIL timeout_response: got result=%h to=%b op=%b, expected 7fc00000 1 10",
                  rsp_result, rsp_timeout, rsp_opcode);
      else passCount++;
      @(negedge clk);
      issueRequest(2'b01, $urandom, $urandom);
      for (int j = 0; j < TB_TIMEOUT; j++) @(negedge clk);
      unit_done   = 4'b0010;
      resModel[1] = r;
      @(negedge clk);
      unit_done = 4'h0;
      checkCount++;
      if ({rsp_valid, rsp_timeout, rsp_result} !== {1'b1, 1'b0, r})
         $display("[TB] FAIL timeout_done_wins: got valid=%b to=%b result=%h, expected 1 0 %h",
                  rsp_valid, rsp_timeout, rsp_result, r);
      else passCount++;
      @(negedge clk);
`else
      logic stuckBad;
      stuckBad = 1'b0;
      @(negedge clk);
      issueRequest(2'b10, $urandom, $urandom);
      unit_done = 4'b1011;
      for (int i = 0; i < 3 * TB_TIMEOUT; i++) begin
         @(negedge clk);
         if (rsp_valid || !busy) stuckBad = 1'b1;
      end
      unit_done = 4'h0;
      checkCount++;
      if (stuckBad !== 1'b0)
         $display("[TB] FAIL no_timeout_wait: got early exit=%b, expected 0", stuckBad);
      else passCount++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkCount++;
      if ({busy, req_ready, rsp_timeout} !== 3'b010)
         $display("[TB] FAIL no_timeout_recover: got busy/ready/to=%b, expected 010", {busy, req_ready, rsp_timeout});
      else passCount++;
`endif
   endtask

   task automatic test_random;
      logic [1:0]  op;
      logic [31:0] expRes;
      logic [3:0]  opMask;
      int          lat;
      int          bp;
      logic        early;
      logic        holdBad;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         op      = 2'($urandom_range(0, 3));
         opMask  = 4'b0001 << op;
         expRes  = $urandom;
         lat     = $urandom_range(1, 5);
         bp      = $urandom_range(0, 3);
         early   = 1'b0;
         holdBad = 1'b0;
         rsp_ready = (bp == 0);
         unit_done = 4'($urandom);
         issueRequest(op, $urandom, $urandom);
         unit_done = 4'($urandom);
         for (int j = 1; j <= lat; j++) begin
            @(negedge clk);
            if (rsp_valid) early = 1'b1;
            for (int u = 0; u < 4; u++) resModel[u] = $urandom;
            if (j == lat) begin
               unit_done    = 4'($urandom) | opMask;
               resModel[op] = expRes;
            end else begin
               unit_done = 4'($urandom) & ~opMask;
            end
         end
         @(negedge clk);
         unit_done = 4'h0;
         checkCount++;
         if ({early, rsp_valid} !== 2'b01)
            $display("[TB] FAIL rnd_latency_%0d: got early/valid=%b with L=%0d, expected 01", n, {early, rsp_valid}, lat);
         else passCount++;
         checkCount++;
         if ({rsp_opcode, rsp_result, rsp_timeout} !== {op, expRes, 1'b0})
            $display("[TB] FAIL rnd_response_%0d: got op=%b result=%h to=%b, expected %b %h 0",
                     n, rsp_opcode, rsp_result, rsp_timeout, op, expRes);
         else passCount++;
         for (int k = 0; k < bp; k++) begin
            for (int u = 0; u < 4; u++) resModel[u] = $urandom;
            unit_done = 4'($urandom);
            @(negedge clk);
            if ({rsp_valid, rsp_result, rsp_opcode} !== {1'b1, expRes, op}) holdBad = 1'b1;
         end
         unit_done = 4'h0;
         rsp_ready = 1'b1;
         checkCount++;
         if (holdBad !== 1'b0)
            $display("[TB] FAIL rnd_hold_%0d: got hold error=%b over %0d stall cycles, expected 0", n, holdBad, bp);
         else passCount++;
         @(negedge clk);
         checkCount++;
         if ({rsp_valid, req_ready} !== 2'b01)
            $display("[TB] FAIL rnd_release_%0d: got valid/ready=%b, expected 01", n, {rsp_valid, req_ready});
         else passCount++;
      end
   endtask

   task automatic test_back_to_back;
      logic [33:0] got [$];
      logic [33:0] expected [4];
      int          acceptCyc [4];
      int          idx;
      logic        pendingAdvance;
      for (int i = 0; i < 4; i++) begin
         resModel[i]  = $urandom;
         expected[i]  = {2'(i), resModel[i]};
         acceptCyc[i] = -100;
      end
      idx            = 0;
      pendingAdvance = 1'b0;
      @(negedge clk);
      rsp_ready  = 1'b1;
      unit_done  = 4'hF;
      req_valid  = 1'b1;
      req_opcode = 2'd0;
      req_a      = $urandom;
      req_b      = $urandom;
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (pendingAdvance) begin
            idx++;
            if (idx < 4) begin
               req_opcode = 2'(idx);
               req_a      = $urandom;
               req_b      = $urandom;
            end else begin
               req_valid = 1'b0;
            end
            pendingAdvance = 1'b0;
         end
         if (rsp_valid && rsp_ready) got.push_back({rsp_opcode, rsp_result});
         if (req_valid && req_ready && idx < 4) begin
            acceptCyc[idx] = cyc;
            pendingAdvance = 1'b1;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      unit_done = 4'h0;
      checkCount++;
      if (got.size() !== 4)
         $display("[TB] FAIL b2b_count: got %0d responses, expected 4", got.size());
      else passCount++;
      for (int i = 0; i < 4; i++) begin
         checkCount++;
         if (i >= got.size())
            $display("[TB] FAIL b2b_resp_%0d: got no response, expected %h", i, expected[i]);
         else if (got[i] !== expected[i])
            $display("[TB] FAIL b2b_resp_%0d: got %h, expected %h", i, got[i], expected[i]);
         else passCount++;
      end
      for (int i = 1; i < 4; i++) begin
         checkCount++;
         if (acceptCyc[i] - acceptCyc[i-1] !== 4)
            $display("[TB] FAIL b2b_spacing_%0d: got %0d cycles between accepts, expected 4",
                     i, acceptCyc[i] - acceptCyc[i-1]);
         else passCount++;
      end
   endtask

   // Hard stop in case the design wedges the bench somewhere unexpected.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      for (int i = 0; i < 4; i++) resModel[i] = '0;
      #1;
      test_reset();
      test_add_basic();
      test_div_noise();
      test_backpressure();
      test_reset_in_wait();
      test_timeout();
      test_random();
      test_back_to_back();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/fpu_op_dispatcher.md
# fpu_op_dispatcher

Issue/collect stage for the single-precision FPU. It accepts one operation request (operands A, B and a 2-bit opcode) over a valid/ready handshake and registers it. It drives the operand/opcode inputs of the per-unit demultiplexers and pulses a start strobe. It then waits for the selected unit's done flag, captures that unit's result and presents it on a valid/ready response port. Only one operation is in flight at a time.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width (IEEE-754 single)
- OP_WIDTH, 2, opcode width; 00 add, 01 sub, 10 mul, 11 div
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with FPU_DISPATCH_TIMEOUT_EN)

Ports:
- Reset is asynchronous and active-high. There is one clock, `clk`, with reset `rst`.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  dispatcher can accept
- req_a, req_b  in  DATA_WIDTH  operands
- req_opcode  in  OP_WIDTH  operation select
- unit_a, unit_b  out  DATA_WIDTH  registered operands to the demux inputs
- unit_opcode  out  OP_WIDTH  registered opcode to the demux select
- unit_start  out  1  one-cycle start strobe to the arithmetic units
- unit_done  in  4  per-unit done; bit0 add, bit1 sub, bit2 mul, bit3 div
- res_add, res_sub, res_mul, res_div  in  DATA_WIDTH  unit results, valid while the matching done bit is high
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  DATA_WIDTH  captured result
- rsp_opcode  out  OP_WIDTH  opcode of the response
- rsp_timeout  out  1  response produced by the watchdog
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch req_a/req_b/req_opcode into unit_a/unit_b/unit_opcode, then go to ISSUE.
  - unit_done is ignored in IDLE.
- ISSUE:
  - unit_start=1 for exactly this one cycle.
  - Go to WAIT unconditionally.
  - unit_done is not sampled in ISSUE; units assert done no earlier than the cycle after start.
- WAIT:
  - When unit_done[unit_opcode]=1, capture the matching res_* into rsp_result and unit_opcode into rsp_opcode, clear rsp_timeout, then go to RESP.
  - Done bits of the non-selected units are ignored.
- RESP:
  - rsp_valid=1. rsp_result, rsp_opcode and rsp_timeout stay stable until rsp_ready=1.
  - On rsp_valid&rsp_ready, go to IDLE.
  - req_ready=0 in this state, so there is no same-cycle re-accept.
- unit_a, unit_b and unit_opcode hold their value until the next accept; they are not cleared on return to IDLE.
- Reset values of all outputs:
  - req_ready=0 while rst is asserted, 1 in the first IDLE cycle after rst deasserts.
  - Every other output is 0; state is IDLE.
- Reset mid-operation aborts immediately: state goes to IDLE, outputs return to reset values, and no response is produced. A late unit_done arriving after reset is ignored.

## Timing
- Request accepted at edge k. unit_start is high in cycle k+1.
- If unit_done[op] first samples high at edge k+1+L (L≥1), rsp_valid rises in cycle k+2+L.
- Minimum accept-to-rsp_valid latency is 3 cycles. Minimum accept-to-accept spacing is 4 cycles (with rsp_ready held high).
- rsp_ready backpressure extends RESP indefinitely with all response outputs held.

## Configuration
- FPU_DISPATCH_TIMEOUT_EN defined:
  - A cycle counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT and increments each WAIT cycle.
  - If done is absent when the counter reaches TIMEOUT_CYCLES, go to RESP with rsp_result=32'h7FC00000 (quiet NaN) and rsp_timeout=1.
  - If done and timeout occur in the same cycle, done wins.
- FPU_DISPATCH_TIMEOUT_EN undefined:
  - There is no counter; WAIT lasts until done.
  - rsp_timeout is tied to 0.

## Test plan
- Add, done after 1 cycle: a=32'h3F800000 (1.0), b=32'h40000000 (2.0), op=00, unit_done[0] with res_add=32'h40400000 -> rsp_valid 3 cycles after accept, rsp_result=32'h40400000, rsp_opcode=00, rsp_timeout=0.
- Div with wrong-unit noise: op=11; pulse unit_done[0] with res_add=32'hDEADBEEF, then unit_done[3] with res_div=32'h3F000000 five cycles later -> rsp_result=32'h3F000000, rsp_opcode=11.
- Backpressure: hold rsp_ready=0 for 10 cycles during RESP -> rsp_valid, rsp_result and rsp_opcode stable, req_ready=0; a req_valid pulse in this window is not accepted.
- Reset in WAIT: assert rst mid-WAIT, then pulse unit_done[op] after release -> all outputs 0 during reset, req_ready=1 after release, no rsp_valid.
- Timeout (macro defined, TIMEOUT_CYCLES=8): op=10 and unit_done never asserted -> rsp_valid with rsp_result=32'h7FC00000 and rsp_timeout=1 after 8 WAIT cycles. Macro undefined: rsp_valid stays 0 and busy stays 1.
- Back-to-back: issue 4 requests (ops 00..11) with rsp_ready=1 and done after 1 cycle -> 4 responses in order with matching opcodes and no lost or duplicated responses.
